keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_TICKS, default 50000, meaning clk cycles per column dwell (one "tick" period); legal range 2..2^20.
REQ-002 SHALL have parameter DEBOUNCE_N, default 4, meaning consecutive identical tick samples required to accept a press or a release; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, meaning system clock; the block's only clock.
REQ-004 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port linha_in, input, 4, meaning keypad row lines, active-low, asynchronous to clk.
REQ-006 SHALL have port coluna_out, output, 4, meaning keypad column drive, active-low one-cold.
REQ-007 SHALL have port key_code, output, 4, meaning code of the last accepted key.
REQ-008 SHALL have port key_valid, output, 1, meaning one-cycle pulse when a new key is accepted.
REQ-009 SHALL have port key_held, output, 1, meaning an accepted key is still pressed.
REQ-010 SHALL have port multi_err, output, 1, meaning one-cycle pulse when a tick sample shows more than one row low.

Function
REQ-011 SHALL pass linha_in through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rows_s).
REQ-012 SHALL run a tick counter 0..SCAN_TICKS-1, wrapping; a tick SHALL occur in the cycle where the count equals SCAN_TICKS-1.
REQ-013 SHALL drive coluna_out = ~(4'b0001 << col), where col is a 2-bit column index; exactly one bit is low at all times.
REQ-014 SHALL implement states SCAN, DEBOUNCE, HELD and RELEASE; state changes SHALL occur only on tick cycles.
REQ-015 In SCAN on a tick: no row low -> col increments (3 wraps to 0); exactly one row low -> capture row index r and col, set press count to 1, go to DEBOUNCE with col frozen; more than one row low -> multi_err pulses in the next cycle, col increments, state stays SCAN.
REQ-016 In DEBOUNCE on a tick: the same single row low -> increment press count; any other pattern (including multi-row) -> return to SCAN with col incremented, no key_valid pulse.
REQ-017 When the press count reaches DEBOUNCE_N (with DEBOUNCE_N=1, directly from SCAN): key_code = 4*r + col and key_valid = 1 in the cycle after that tick; go to HELD.
REQ-018 key_valid SHALL be high for exactly one cycle per accepted press; key_code SHALL hold its value until the next accepted press.
REQ-019 key_held SHALL be 1 from the key_valid cycle until the release is accepted, with col frozen throughout.
REQ-020 In HELD or RELEASE on a tick: all rows high -> increment release count; otherwise -> clear release count and stay in or return to HELD; at DEBOUNCE_N -> key_held = 0 in the next cycle, go to SCAN with col incremented.
REQ-021 Other keys pressed while in HELD SHALL be ignored; no key_valid or multi_err pulse SHALL occur until the release is accepted.
REQ-022 Tick counter width SHALL be ceil(log2(SCAN_TICKS)) bits; debounce counters SHALL be 4 bits and saturate at DEBOUNCE_N.

Reset
REQ-023 On a clk edge with reset = 1: state = SCAN, col = 0, coluna_out = 4'b1110, key_code = 0, key_valid = 0, key_held = 0, multi_err = 0, tick counter = 0, both debounce counts = 0, synchronizer flops = 4'b1111.
REQ-024 Reset asserted mid-press or mid-debounce SHALL abandon the operation with no pulse; after reset is released, a key still held SHALL be re-detected from SCAN.

Verification (SCAN_TICKS=4, DEBOUNCE_N=2)
REQ-025 Reset, rows idle (4'b1111) -> coluna_out cycles 1110, 1101, 1011, 0111, 1110, each for 4 clks; no pulses.
REQ-026 Hold row 2 low while col 1 is driven, for 3 ticks -> one key_valid pulse with key_code = 9 after the 2nd confirming tick; key_held = 1; coluna_out frozen at 1101.
REQ-027 Row 2 low for only 1 tick (bounce) -> no key_valid pulse; scan resumes at col 2.
REQ-028 Rows 0 and 3 low together while col 0 is driven -> one multi_err pulse; col advances to 1; no key_valid pulse.
REQ-029 Release the key from REQ-026 with a glitch (low-high-low-high-high) -> key_held falls only after 2 consecutive high ticks; the next press yields a new key_valid pulse.
REQ-030 Assert reset 1 cycle while in DEBOUNCE -> all outputs return to their reset values next cycle; no stale key_valid pulse afterwards.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks a one-cold column drive, debounces single-key
// presses and releases on column-dwell ticks, and flags multi-row samples.
module keypad_scanner #(
   parameter int SCAN_TICKS = 50000,
   parameter int DEBOUNCE_N = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] linha_in,
   output logic [3:0] coluna_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic       multi_err
);

   localparam int TW = $clog2(SCAN_TICKS);
   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
   localparam logic [3:0] DN = 4'(DEBOUNCE_N);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   state_t        state;
   logic [3:0]    sync1_reg;
   logic [3:0]    rows_s;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [1:0]    col;
   logic [1:0]    row_cap;
   logic [3:0]    press_cnt;
   logic [3:0]    rel_cnt;
   logic [3:0]    press_inc;
   logic [3:0]    rel_inc;
   logic          none_low;
   logic          single_low;
   logic [1:0]    row_idx;
   logic          press_done;

   assign tick       = (tick_cnt == TICK_LAST);
   assign none_low   = (rows_s == 4'hF);
   assign press_inc  = press_cnt + 4'd1;
   assign rel_inc    = rel_cnt + 4'd1;
   assign coluna_out = ~(4'b0001 << col);

   always_comb begin
      single_low = 1'b1;
      row_idx    = 2'd0;
      case (rows_s)
         4'b1110: row_idx = 2'd0;
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         4'b0111: row_idx = 2'd3;
         default: single_low = 1'b0;
      endcase
   end

   // A press completes either straight from SCAN (single-sample debounce) or
   // when the same row has been seen on DEBOUNCE_N consecutive ticks.
   always_comb begin
      press_done = 1'b0;
      if (tick && single_low) begin
         if (state == SCAN && DEBOUNCE_N == 1)
            press_done = 1'b1;
         else if (state == DEBOUNCE && row_idx == row_cap && press_inc >= DN)
            press_done = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SCAN;
         sync1_reg <= 4'hF;
         rows_s    <= 4'hF;
         tick_cnt  <= '0;
         col       <= 2'd0;
         row_cap   <= 2'd0;
         press_cnt <= 4'd0;
         rel_cnt   <= 4'd0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         multi_err <= 1'b0;
      end else begin
         sync1_reg <= linha_in;
         rows_s    <= sync1_reg;
         tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
         key_valid <= 1'b0;
         multi_err <= 1'b0;
         if (press_done) begin
            key_code  <= {row_idx, col};
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            press_cnt <= DN;
            rel_cnt   <= 4'd0;
            state     <= HELD;
         end else if (tick) begin
            case (state)
               SCAN: begin
                  if (none_low) begin
                     col <= col + 2'd1;
                  end else if (single_low) begin
                     row_cap   <= row_idx;
                     press_cnt <= 4'd1;
                     state     <= DEBOUNCE;
                  end else begin
                     multi_err <= 1'b1;
                     col       <= col + 2'd1;
                  end
               end
               DEBOUNCE: begin
                  if (single_low && row_idx == row_cap) begin
                     press_cnt <= press_inc;
                  end else begin
                     press_cnt <= 4'd0;
                     col       <= col + 2'd1;
                     state     <= SCAN;
                  end
               end
               HELD, RELEASE: begin
                  // Any low row, including a different key, restarts the release run.
                  if (!none_low) begin
                     rel_cnt <= 4'd0;
                     state   <= HELD;
                  end else if (rel_inc >= DN) begin
                     rel_cnt  <= 4'd0;
                     key_held <= 1'b0;
                     col      <= col + 2'd1;
                     state    <= SCAN;
                  end else begin
                     rel_cnt <= rel_inc;
                     state   <= RELEASE;
                  end
               end
               default: state <= SCAN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus random keypad activity, all
// compared cycle by cycle with a tick-level behavioural model of the scanner.
module tb_keypad_scanner;

   localparam int ST = 4;
   localparam int DN = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] linha_in = 4'hF;
   logic [3:0] coluna_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   logic       multi_err;

   int errors = 0;
   int checks = 0;
   int valid_seen = 0;
   int merr_seen = 0;

   // model state
   int         m_col, m_code, m_cand, m_conf, m_rel, m_phase;
   bit         m_valid, m_held, m_merr;
   logic [3:0] h_new, h_old;

   keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_N(DN)) dut (
      .clk(clk),
      .reset(reset),
      .linha_in(linha_in),
      .coluna_out(coluna_out),
      .key_code(key_code),
      .key_valid(key_valid),
      .key_held(key_held),
      .multi_err(multi_err)
   );

   always #5 clk = ~clk;

   function automatic int zeros(input logic [3:0] v);
      int n = 0;
      for (int i = 0; i < 4; i++) if (v[i] == 1'b0) n++;
      return n;
   endfunction

   function automatic int low_row(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i] == 1'b0) return i;
      return -1;
   endfunction

   // Physical keypad: key (r,c) pulls row r low only while column c is driven.
   function automatic logic [3:0] phys(input int r, input int c);
      logic [3:0] one = 4'h1;
      if (coluna_out[c] == 1'b0) return ~(one << r);
      return 4'hF;
   endfunction

   task automatic model_accept();
      m_code  = 4 * m_cand + m_col;
      m_valid = 1;
      m_held  = 1;
      m_rel   = 0;
      m_cand  = -1;
   endtask

   task automatic model_edge(input logic [3:0] rows, input bit rst);
      logic [3:0] rs;
      bit tk;
      if (rst) begin
         m_col = 0; m_code = 0; m_cand = -1; m_conf = 0; m_rel = 0; m_phase = 0;
         m_valid = 0; m_held = 0; m_merr = 0;
         h_new = 4'hF; h_old = 4'hF;
         return;
      end
      rs      = h_old;
      h_old   = h_new;
      h_new   = rows;
      tk      = (m_phase == ST - 1);
      m_phase = (m_phase + 1) % ST;
      m_valid = 0;
      m_merr  = 0;
      if (!tk) return;
      if (!m_held) begin
         if (m_cand < 0) begin
            if (zeros(rs) == 0) m_col = (m_col + 1) % 4;
            else if (zeros(rs) == 1) begin
               m_cand = low_row(rs);
               m_conf = 1;
               if (m_conf >= DN) model_accept();
            end else begin
               m_merr = 1;
               m_col  = (m_col + 1) % 4;
            end
         end else if (zeros(rs) == 1 && low_row(rs) == m_cand) begin
            m_conf++;
            if (m_conf >= DN) model_accept();
         end else begin
            m_cand = -1;
            m_conf = 0;
            m_col  = (m_col + 1) % 4;
         end
      end else if (rs == 4'hF) begin
         m_rel++;
         if (m_rel >= DN) begin
            m_held = 0;
            m_rel  = 0;
            m_col  = (m_col + 1) % 4;
         end
      end else begin
         m_rel = 0;
      end
   endtask

   task automatic cycle(input logic [3:0] rows, input bit rst);
      logic [3:0] one = 4'h1;
      logic [3:0] exp_cols;
      linha_in = rows;
      reset    = rst;
      @(posedge clk);
      model_edge(rows, rst);
      #1;
      exp_cols = ~(one << m_col);
      checks += 5;
      if (coluna_out !== exp_cols) begin
         errors++;
         $display("FAIL coluna_out got=%b want=%b t=%0t", coluna_out, exp_cols, $time);
      end
      if (key_code !== 4'(m_code)) begin
         errors++;
         $display("FAIL key_code got=%0d want=%0d t=%0t", key_code, m_code, $time);
      end
      if (key_valid !== m_valid) begin
         errors++;
         $display("FAIL key_valid got=%b want=%b t=%0t", key_valid, m_valid, $time);
      end
      if (key_held !== m_held) begin
         errors++;
         $display("FAIL key_held got=%b want=%b t=%0t", key_held, m_held, $time);
      end
      if (multi_err !== m_merr) begin
         errors++;
         $display("FAIL multi_err got=%b want=%b t=%0t", multi_err, m_merr, $time);
      end
      if (key_valid === 1'b1) begin
         valid_seen++;
         $display("key accepted code=%0d t=%0t", key_code, $time);
      end
      if (multi_err === 1'b1) begin
         merr_seen++;
         $display("multi-row sample t=%0t", $time);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(4'hF, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (coluna_out !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 ||
          key_held !== 1'b0 || multi_err !== 1'b0) begin
         errors++;
         $display("FAIL %s got col=%b code=%0d v=%b h=%b m=%b want col=1110 code=0 v=0 h=0 m=0",
                  tag, coluna_out, key_code, key_valid, key_held, multi_err);
      end
   endtask

   task automatic test_reset();
      cycle(4'hF, 1);
      cycle(4'hF, 1);
      check_reset_outputs("reset_values");
   endtask

   task automatic test_idle_scan();
      logic [3:0] one = 4'h1;
      logic [3:0] want;
      valid_seen = 0;
      merr_seen  = 0;
      for (int k = 1; k <= 20; k++) begin
         cycle(4'hF, 0);
         want = ~(one << ((k / ST) % 4));
         checks++;
         if (coluna_out !== want) begin
            errors++;
            $display("FAIL idle_seq k=%0d got=%b want=%b", k, coluna_out, want);
         end
      end
      checks++;
      if (valid_seen != 0 || merr_seen != 0) begin
         errors++;
         $display("FAIL idle_pulses got valid=%0d merr=%0d want 0 0", valid_seen, merr_seen);
      end
   endtask

   task automatic test_press();
      valid_seen = 0;
      for (int i = 0; i < 40; i++) cycle(phys(2, 1), 0);
      checks++;
      if (valid_seen != 1 || key_code !== 4'd9) begin
         errors++;
         $display("FAIL press_key got pulses=%0d code=%0d want 1 9", valid_seen, key_code);
      end
      checks++;
      if (key_held !== 1'b1 || coluna_out !== 4'b1101) begin
         errors++;
         $display("FAIL press_held got held=%b col=%b want 1 1101", key_held, coluna_out);
      end
   endtask

   task automatic test_release_glitch();
      logic [3:0] pat [4] = '{4'b1011, 4'hF, 4'b1011, 4'hF};
      for (int b = 0; b < 4; b++)
         for (int i = 0; i < ST; i++) cycle(pat[b], 0);
      checks++;
      if (key_held !== 1'b1) begin
         errors++;
         $display("FAIL release_glitch_held got=%b want=1", key_held);
      end
      for (int i = 0; i < ST + 3; i++) cycle(4'hF, 0);
      checks++;
      if (key_held !== 1'b0) begin
         errors++;
         $display("FAIL release_done got=%b want=0", key_held);
      end
      valid_seen = 0;
      for (int i = 0; i < 60; i++) cycle(phys(0, 3), 0);
      checks++;
      if (valid_seen != 1 || key_code !== 4'd3) begin
         errors++;
         $display("FAIL next_press got pulses=%0d code=%0d want 1 3", valid_seen, key_code);
      end
      idle(20);
   endtask

   task automatic test_bounce();
      idle(8);
      valid_seen = 0;
      for (int i = 0; i < ST; i++) cycle(4'b1011, 0);
      idle(20);
      checks++;
      if (valid_seen != 0) begin
         errors++;
         $display("FAIL bounce got pulses=%0d want=0", valid_seen);
      end
   endtask

   task automatic test_multi();
      idle(8);
      valid_seen = 0;
      merr_seen  = 0;
      for (int i = 0; i < ST; i++) cycle(4'b0110, 0);
      idle(8);
      checks++;
      if (merr_seen != 1 || valid_seen != 0) begin
         errors++;
         $display("FAIL multi got merr=%0d valid=%0d want 1 0", merr_seen, valid_seen);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      idle(8);
      while (m_cand < 0 && n < 20) begin
         cycle(4'b1011, 0);
         n++;
      end
      checks++;
      if (m_cand < 0) begin
         errors++;
         $display("FAIL reach_debounce got cycles=%0d want capture within 20", n);
      end
      cycle(4'b1011, 1);
      check_reset_outputs("reset_mid");
      valid_seen = 0;
      idle(30);
      checks++;
      if (valid_seen != 0) begin
         errors++;
         $display("FAIL stale_pulse got=%0d want=0", valid_seen);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 150; it++) begin
         int act = $urandom_range(0, 9);
         if (act < 4) begin
            int r = $urandom_range(0, 3);
            int c = $urandom_range(0, 3);
            int d = $urandom_range(1, 50);
            for (int i = 0; i < d; i++) cycle(phys(r, c), 0);
         end else if (act < 6) begin
            int d = $urandom_range(1, 6);
            for (int i = 0; i < d; i++) cycle(4'($urandom), 0);
         end else if (act < 9) begin
            idle($urandom_range(1, 20));
         end else begin
            cycle(4'hF, 1);
         end
      end
      idle(30);
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_press();
      test_release_glitch();
      test_bounce();
      test_multi();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
